seq_shift_multiplier: RTL and testbench
=======================================

// Module: seq_shift_multiplier
// PURPOSE
//   Multi-cycle radix-2 shift-and-add multiplier for the KGP-RISC ALU datapath.
//   Sits directly upstream of the Left_Shift/product path. It takes two register
//   operands and iterates one multiplier bit per cycle, accumulating shifted
//   multiplicand copies. It hands a registered 2*WIDTH-bit product to writeback
//   through a start/busy/done handshake.
// PARAMETERS
//   WIDTH      32   operand width in bits; product is 2*WIDTH bits
//   CNT_W      6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk        in   1         rising-edge clock
//   rst_n      in   1         asynchronous active-low reset
//   start      in   1         request; sampled only in IDLE
//   signed_op  in   1         1 = two's-complement operands, 0 = unsigned
//   a          in   WIDTH     multiplicand, sampled with start
//   b          in   WIDTH     multiplier, sampled with start
//   busy       out  1         high in CALC and FIN
//   done       out  1         one-cycle pulse; product valid from this cycle
//   product    out  2*WIDTH   registered result; holds until the next done
// BEHAVIOUR
//   Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
//   Reset: state=IDLE; busy=0; done=0; product=0; count=0; internal regs=0.
//   FSM states: IDLE -> CALC -> FIN -> IDLE.
//   - IDLE, start=1 at edge E0:
//       latch |a| and |b| (magnitudes if signed_op, else raw);
//       neg = signed_op & (a[MSB]^b[MSB]); acc=0; count=0; go to CALC.
//   - CALC, one edge per bit:
//       if mult[0], acc += mcand<<count (2*WIDTH-bit add, no overflow possible);
//       mult >>= 1; count++.
//       Go to FIN after the edge where count reaches WIDTH-1 (WIDTH CALC edges, E1..E_W).
//   - FIN, edge E_(W+1):
//       product <= neg ? -acc : acc; done <= 1; busy <= 0; go to IDLE.
//   Latency: done is high in the cycle after E_(W+1), i.e. WIDTH+2 edges after the start edge.
//   Back-to-back: start may be high in the same cycle as done (state IDLE) and is accepted.
//   start during CALC/FIN is ignored. It is not queued. Operand changes while busy have no effect.
//   The most negative operand (0x8000_0000 signed): magnitude 2**(WIDTH-1) is
//     representable unsigned; the result is exact (e.g. -2^31 * -1 = +2^31).
//   signed_op=0 treats the MSB as magnitude; neg is forced to 0.
//   Reset asserted mid-operation: immediate return to the reset values above; no done pulse.
//     The partial result is discarded. The first start after rst_n rises is accepted normally.
//   done is never high for two consecutive cycles; busy and done are never both high.
// CONFIGURATION
//   EARLY_TERM_EN defined:
//     - In CALC, if the remaining mult (after the current shift) is 0, go to FIN on that edge.
//     - Latency becomes (index of highest set |b| bit)+3 edges to done. For |b|=0, done is 3 edges
//       after start (one CALC edge).
//     - Results are identical to the non-early build.
//   EARLY_TERM_EN undefined: fixed WIDTH-iteration latency for every operand pair.
// TESTING
//   1. Reset values: hold rst_n=0 -> busy=0, done=0, product=0.
//      Release; no start for 10 cycles -> outputs unchanged.
//   2. a=5, b=4, signed_op=0:
//      - product=64'd20.
//      - done exactly 34 edges after start (non-early); 5 edges with EARLY_TERM_EN.
//   3. a=-5 (0xFFFF_FFFB), b=4, signed_op=1 -> product=64'hFFFF_FFFF_FFFF_FFEC.
//      Same operands with signed_op=0 -> 64'h0000_0003_FFFF_FFEC.
//   4. a=b=32'hFFFF_FFFF:
//      - signed_op=0 -> 64'hFFFF_FFFE_0000_0001.
//      - signed_op=1 -> 64'd1.
//      a=32'h8000_0000, b=32'hFFFF_FFFF, signed_op=1 -> 64'h0000_0000_8000_0000.
//   5. Start 5*4. At edge 10, pulse start with a=7, b=7 -> ignored; product=20, one done pulse.
//      Then start on the done cycle with a=3, b=3 -> product=9 after the next done.
//   6. Start 5*4. Assert rst_n=0 at edge 12 for 2 cycles:
//      - busy drops immediately; no done; product stays 0.
//      - A new start 6*7 -> product=42.

Source files
------------

// File: rtl/seq_shift_multiplier_if.sv
// Handshake and operand/result bundle for seq_shift_multiplier.
// The master drives start/operands; the slave (multiplier) returns busy/done/product.
interface seq_shift_multiplier_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 signed_op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, signed_op, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_op, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_shift_multiplier.sv
// Radix-2 shift-and-add multiplier, one multiplier bit per CALC cycle, sign applied in FIN.
// Optional macro EARLY_TERM_EN: leave CALC as soon as the remaining multiplier bits are all zero.
module seq_shift_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_shift_multiplier_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mult_q, mult_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     magA, magB;
  logic [2*WIDTH-1:0]   mcandExt;

  // The most negative operand negates to itself, which is exactly its unsigned magnitude.
  assign magA     = (bus.signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign magB     = (bus.signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign mcandExt = {{WIDTH{1'b0}}, mcand_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mult_q    <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mult_q    <= mult_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mult_d    = mult_q;
    acc_d     = acc_q;
    count_d   = count_q;
    neg_d     = neg_q;
    product_d = product_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = magA;
          mult_d  = magB;
          neg_d   = bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d   = '0;
          count_d = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (mult_q[0]) begin
          acc_d = acc_q + (mcandExt << count_q);
        end
        mult_d  = mult_q >> 1;
        count_d = count_q + 1'b1;
`ifdef EARLY_TERM_EN
        if ((mult_d == '0) || (count_q == CNT_W'(WIDTH-1))) begin
          state_d = FIN;
        end
`else
        if (count_q == CNT_W'(WIDTH-1)) begin
          state_d = FIN;
        end
`endif
      end
      FIN: begin
        product_d = neg_q ? -acc_q : acc_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_seq_shift_multiplier.sv
// Self-checking bench for seq_shift_multiplier: arithmetic reference model, per-cycle compare
// process, literal pins for the model, randomized operands. Honors EARLY_TERM_EN for latency.
module tb_seq_shift_multiplier;

  localparam int WIDTH = 32;
`ifdef EARLY_TERM_EN
  localparam int IGN_EDGE = 3;
  localparam int RST_EDGE = 3;
`else
  localparam int IGN_EDGE = 10;
  localparam int RST_EDGE = 12;
`endif

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seq_shift_multiplier_if #(.WIDTH(WIDTH)) bus ();

  seq_shift_multiplier #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] expQ[$];
  logic [63:0] heldProduct = '0;
  logic        prevDone    = 1'b0;
  logic [63:0] p;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Exact product from plain integer arithmetic on the original operands.
  function automatic logic [63:0] modelProduct(input logic [31:0] a, input logic [31:0] b,
                                               input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'h0, a} * {32'h0, b};
  endfunction

  // Edges from the start edge (inclusive) to the first edge after which done is high.
  function automatic int expLatency(input logic [31:0] b, input logic s);
    logic [31:0] m;
    int          idx;
    m   = (s && b[31]) ? -b : b;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) idx = i;
    end
`ifdef EARLY_TERM_EN
    return idx + 3;
`else
    return (idx >= 0) ? WIDTH + 2 : 0;
`endif
  endfunction

  // Every cycle: reset values while in reset, otherwise done/busy rules and product vs model.
  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      heldProduct = '0;
      prevDone    = 1'b0;
      checkOutput("reset busy", 64'(bus.busy), 64'd0);
      checkOutput("reset done", 64'(bus.done), 64'd0);
      checkOutput("reset product", bus.product, 64'd0);
    end else begin
      checkOutput("busy and done together", 64'(bus.busy & bus.done), 64'd0);
      if (bus.done) begin
        checkOutput("done two cycles", 64'(prevDone), 64'd0);
        if (expQ.size() == 0) begin
          checkOutput("unexpected done", 64'd1, 64'd0);
        end else begin
          heldProduct = expQ.pop_front();
          checkOutput("product at done", bus.product, heldProduct);
        end
      end else begin
        checkOutput("product hold", bus.product, heldProduct);
      end
      prevDone = bus.done;
    end
  end

  task automatic launchOp(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.a         = a;
    bus.b         = b;
    bus.signed_op = s;
    bus.start     = 1'b1;
    expQ.push_back(modelProduct(a, b, s));
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.signed_op = 1'($urandom_range(0, 1));
  endtask

  task automatic waitDone(input int startEdges, input int expEdges, input string name,
                          output logic [63:0] prod);
    int edges = startEdges;
    bit seen  = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      edges++;
      #1;
      if (bus.done) seen = 1'b1;
    end
    if (!seen) checkOutput({name, " timeout"}, 64'd0, 64'd1);
    else       checkOutput({name, " latency"}, 64'(edges), 64'(expEdges));
    prod = bus.product;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                               input string name, output logic [63:0] prod);
    launchOp(a, b, s);
    waitDone(1, expLatency(b, s), name, prod);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.a         = '0;
    bus.b         = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("init busy", 64'(bus.busy), 64'd0);
    checkOutput("init done", 64'(bus.done), 64'd0);
    checkOutput("init product", bus.product, 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("idle busy", 64'(bus.busy), 64'd0);
    checkOutput("idle done", 64'(bus.done), 64'd0);
    checkOutput("idle product", bus.product, 64'd0);

    applyStimulus(32'd5, 32'd4, 1'b0, "5x4", p);
    checkOutput("5x4 literal", p, 64'd20);

    applyStimulus(32'hFFFF_FFFB, 32'd4, 1'b1, "-5x4 signed", p);
    checkOutput("-5x4 signed literal", p, 64'hFFFF_FFFF_FFFF_FFEC);
    applyStimulus(32'hFFFF_FFFB, 32'd4, 1'b0, "-5x4 unsigned", p);
    checkOutput("-5x4 unsigned literal", p, 64'h0000_0003_FFFF_FFEC);

    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "ones unsigned", p);
    checkOutput("ones unsigned literal", p, 64'hFFFF_FFFE_0000_0001);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "ones signed", p);
    checkOutput("ones signed literal", p, 64'd1);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "minneg x -1", p);
    checkOutput("minneg x -1 literal", p, 64'h0000_0000_8000_0000);

    // Start while busy must be ignored; then a back-to-back start on the done cycle.
    launchOp(32'd5, 32'd4, 1'b0);
    repeat (IGN_EDGE - 2) @(posedge clk);
    #1;
    bus.a         = 32'd7;
    bus.b         = 32'd7;
    bus.signed_op = 1'b0;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    waitDone(IGN_EDGE, expLatency(32'd4, 1'b0), "ignored start", p);
    checkOutput("ignored start literal", p, 64'd20);
    launchOp(32'd3, 32'd3, 1'b0);
    waitDone(1, expLatency(32'd3, 1'b0), "back-to-back", p);
    checkOutput("back-to-back literal", p, 64'd9);

    // Reset in the middle of an operation discards it.
    launchOp(32'd5, 32'd4, 1'b0);
    repeat (RST_EDGE - 1) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset busy", 64'(bus.busy), 64'd0);
    checkOutput("mid reset done", 64'(bus.done), 64'd0);
    checkOutput("mid reset product", bus.product, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(32'd6, 32'd7, 1'b0, "6x7 after reset", p);
    checkOutput("6x7 literal", p, 64'd42);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        2:       ra = 32'd0;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'h8000_0000;
        1:       rb = 32'd1;
        2:       rb = 32'($urandom_range(0, 255));
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rs, "random", p);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
